// File: rtl/hex_nibble_feeder.sv
// Serialises a word MSB-nibble first onto a seven-segment shift chain (nib + falling-edge shift).
// Optional HEX_FEED_PENDING_EN adds a one-entry pending word for starts that arrive while busy.
module hex_nibble_feeder #(
   parameter int NIBBLES       = 8,
   parameter int STROBE_CYCLES = 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   start_i,
   input  logic [4*NIBBLES-1:0]   word_i,
   output logic [3:0]             nib_o,
   output logic                   shift_o,
   output logic                   busy_o,
   output logic                   done_o
);
   localparam int W  = 4*NIBBLES;
   localparam int CW = $clog2(NIBBLES+1);
   localparam int SW = $clog2(STROBE_CYCLES+1);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_DONE} state_t;

   state_t          state_q, state_d;
   logic [W-1:0]    sreg_q, sreg_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SW-1:0]   scnt_q, scnt_d;
   logic [3:0]      nib_q, nib_d;
   logic            shift_q, shift_d, busy_q, busy_d, done_q, done_d;

   logic            ready, load_en;
   logic [W-1:0]    load_word;

   assign ready = (state_q == S_IDLE) || (state_q == S_DONE);

`ifdef HEX_FEED_PENDING_EN
   logic            pend_vld_q;
   logic [W-1:0]    pend_word_q;

   // A fresh start at the ready point wins over the parked word, which is then dropped.
   assign load_en   = ready && (start_i || pend_vld_q);
   assign load_word = start_i ? word_i : pend_word_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_vld_q  <= 1'b0;
         pend_word_q <= '0;
      end else if (!ready && start_i) begin
         pend_vld_q  <= 1'b1;
         pend_word_q <= word_i;
      end else if (load_en) begin
         pend_vld_q  <= 1'b0;
      end
   end
`else
   assign load_en   = ready && start_i;
   assign load_word = word_i;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         sreg_q  <= '0;
         cnt_q   <= '0;
         scnt_q  <= '0;
         nib_q   <= '0;
         shift_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         scnt_q  <= scnt_d;
         nib_q   <= nib_d;
         shift_q <= shift_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      scnt_d  = scnt_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (load_en) begin
               sreg_d  = load_word;
               cnt_d   = CW'(NIBBLES);
               state_d = S_SETUP;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SETUP: begin
            scnt_d  = '0;
            state_d = S_STROBE;
         end
         S_STROBE: begin
            if (scnt_q == SW'(STROBE_CYCLES-1)) state_d = S_HOLD;
            else                                scnt_d  = scnt_q + SW'(1);
         end
         S_HOLD: begin
            sreg_d  = sreg_q << 4;
            cnt_d   = cnt_q - CW'(1);
            state_d = (cnt_q == CW'(1)) ? S_DONE : S_SETUP;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are registered decodes of the current state, so they trail it by one cycle;
   // nib only loads in SETUP, which keeps it frozen across STROBE and HOLD.
   always_comb begin
      nib_d   = nib_q;
      shift_d = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         S_SETUP: begin
            nib_d  = sreg_q[W-1 -: 4];
            busy_d = 1'b1;
         end
         S_STROBE: begin
            shift_d = 1'b1;
            busy_d  = 1'b1;
         end
         S_HOLD:  busy_d = 1'b1;
         S_DONE:  done_d = 1'b1;
         default: ;
      endcase
   end

   assign nib_o   = nib_q;
   assign shift_o = shift_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;
endmodule

// File: tb/tb_hex_nibble_feeder.sv
// Directed bench for hex_nibble_feeder: scoreboard of expected nibbles checked at each shift fall.
module tb_hex_nibble_feeder;
   logic        clk = 1'b0, rst = 1'b1, start = 1'b0, start3 = 1'b0;
   logic [31:0] word = '0, word3 = '0;
   logic [3:0]  nib[2];
   logic        sh[2], bz[2], dn[2];

   int checks = 0, errors = 0, viol = 0;
   int falls[2] = '{0, 0};
   int dones[2] = '{0, 0};
   int f0, f1, d0;
   logic [3:0] exp_q0[$], exp_q1[$];
   logic [3:0] nibp[2] = '{4'h0, 4'h0};
   logic       shp[2]  = '{1'b0, 1'b0};
   logic       dnp[2]  = '{1'b0, 1'b0};
   logic       rstp    = 1'b1;

   always #5 clk = ~clk;

   hex_nibble_feeder #(.NIBBLES(8), .STROBE_CYCLES(1)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .word_i(word),
      .nib_o(nib[0]), .shift_o(sh[0]), .busy_o(bz[0]), .done_o(dn[0]));

   hex_nibble_feeder #(.NIBBLES(8), .STROBE_CYCLES(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .start_i(start3), .word_i(word3),
      .nib_o(nib[1]), .shift_o(sh[1]), .busy_o(bz[1]), .done_o(dn[1]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_word(input int d, input logic [31:0] w);
      for (int i = 7; i >= 0; i--) begin
         if (d == 0) exp_q0.push_back(w[4*i +: 4]);
         else        exp_q1.push_back(w[4*i +: 4]);
      end
   endtask

   // The chain captures the nib that was present while shift was high.
   always @(negedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (shp[d] && !sh[d]) begin
            falls[d]++;
            if (d == 0) begin
               if (exp_q0.size() == 0) chk("dut_unexpected_shift", 32'(nibp[d]), 32'hFFFF);
               else chk("dut_nib_at_fall", 32'(nibp[d]), 32'(exp_q0.pop_front()));
            end else begin
               if (exp_q1.size() == 0) chk("dut3_unexpected_shift", 32'(nibp[d]), 32'hFFFF);
               else chk("dut3_nib_at_fall", 32'(nibp[d]), 32'(exp_q1.pop_front()));
            end
         end
         if ((sh[d] || shp[d]) && !rstp && (nib[d] !== nibp[d])) viol++;
         if (dn[d] && !dnp[d]) dones[d]++;
         nibp[d] = nib[d];
         shp[d]  = sh[d];
         dnp[d]  = dn[d];
      end
      rstp = rst;
   end

   initial begin
      // Reset state
      cyc(2);
      chk("rst_nib", 32'(nib[0]), 0);
      chk("rst_shift", 32'(sh[0]), 0);
      chk("rst_busy", 32'(bz[0]), 0);
      chk("rst_done", 32'(dn[0]), 0);
      chk("rst_busy3", 32'(bz[1]), 0);
      rst = 1'b0;
      cyc(1);

      // Single word on both instances; word changes after accept must not matter
      start = 1'b1; word = 32'h1234_ABCD; push_word(0, word);
      start3 = 1'b1; word3 = 32'h89AB_CDEF; push_word(1, word3);
      f0 = falls[0]; f1 = falls[1];
      cyc(1);
      start = 1'b0; start3 = 1'b0; word = '1; word3 = '0;
      chk("busy_at_k", 32'(bz[0]), 0);
      for (int c = 1; c <= 41; c++) begin
         cyc(1);
         if (c == 1)  chk("busy_k1", 32'(bz[0]), 1);
         if (c == 1)  chk("shift_k1", 32'(sh[0]), 0);
         if (c == 2)  chk("shift_k2", 32'(sh[0]), 1);
         if (c == 3)  chk("shift_k3_hold", 32'(sh[0]), 0);
         if (c == 5)  chk("shift_k5", 32'(sh[0]), 1);
         if (c == 24) chk("done_k24", 32'(dn[0]), 0);
         if (c == 25) chk("done_k25", 32'(dn[0]), 1);
         if (c == 25) chk("busy_k25", 32'(bz[0]), 0);
         if (c == 26) chk("done_k26", 32'(dn[0]), 0);
         if (c == 4)  chk("s3_shift_k4", 32'(sh[1]), 1);
         if (c == 5)  chk("s3_shift_k5", 32'(sh[1]), 0);
         if (c == 7)  chk("s3_shift_k7", 32'(sh[1]), 1);
         if (c == 40) chk("s3_done_k40", 32'(dn[1]), 0);
         if (c == 41) chk("s3_done_k41", 32'(dn[1]), 1);
      end
      chk("single_falls", 32'(falls[0] - f0), 8);
      chk("s3_falls", 32'(falls[1] - f1), 8);
      chk("single_queue", 32'(exp_q0.size()), 0);
      chk("s3_queue", 32'(exp_q1.size()), 0);

      // Back-to-back: second start lands in the DONE state cycle
      cyc(2);
      start = 1'b1; word = 32'hFFFF_0000; push_word(0, word); push_word(0, 32'h0F0F_0F0F);
      f0 = falls[0]; d0 = dones[0];
      cyc(1);
      start = 1'b0;
      cyc(24);
      start = 1'b1; word = 32'h0F0F_0F0F;
      cyc(1);
      start = 1'b0; word = '0;
      chk("b2b_done1", 32'(dn[0]), 1);
      cyc(1);
      chk("b2b_busy_again", 32'(bz[0]), 1);
      cyc(1);
      chk("b2b_first_shift", 32'(sh[0]), 1);
      cyc(23);
      chk("b2b_done2", 32'(dn[0]), 1);
      cyc(2);
      chk("b2b_falls", 32'(falls[0] - f0), 16);
      chk("b2b_dones", 32'(dones[0] - d0), 2);
      chk("b2b_queue", 32'(exp_q0.size()), 0);

      // Start while busy
      cyc(2);
      start = 1'b1; word = 32'h1357_9BDF; push_word(0, word);
      f0 = falls[0];
      cyc(1);
      start = 1'b0;
      cyc(9);
      start = 1'b1; word = 32'h5555_5555;
`ifdef HEX_FEED_PENDING_EN
      push_word(0, word);
`endif
      cyc(1);
      start = 1'b0;
      cyc(50);
`ifdef HEX_FEED_PENDING_EN
      chk("busy_start_falls", 32'(falls[0] - f0), 16);
`else
      chk("busy_start_falls", 32'(falls[0] - f0), 8);
`endif
      chk("busy_start_queue", 32'(exp_q0.size()), 0);
      chk("busy_start_idle", 32'(bz[0]), 0);

      // Reset during STROBE of nibble 3: forced fall captures nibble 3, nothing after
      cyc(2);
      start = 1'b1; word = 32'h9876_5432;
      exp_q0.push_back(4'h9); exp_q0.push_back(4'h8);
      exp_q0.push_back(4'h7); exp_q0.push_back(4'h6);
      f0 = falls[0];
      cyc(1);
      start = 1'b0;
      cyc(11);
      chk("rst_mid_pre_shift", 32'(sh[0]), 1);
      rst = 1'b1;
      cyc(1);
      chk("rst_mid_nib", 32'(nib[0]), 0);
      chk("rst_mid_shift", 32'(sh[0]), 0);
      chk("rst_mid_busy", 32'(bz[0]), 0);
      chk("rst_mid_done", 32'(dn[0]), 0);
      rst = 1'b0;
      cyc(20);
      chk("rst_mid_falls", 32'(falls[0] - f0), 4);
      chk("rst_mid_queue", 32'(exp_q0.size()), 0);

      start = 1'b1; word = 32'h0000_0001; push_word(0, word);
      f0 = falls[0];
      cyc(1);
      start = 1'b0;
      cyc(25);
      chk("post_rst_done", 32'(dn[0]), 1);
      cyc(2);
      chk("post_rst_falls", 32'(falls[0] - f0), 8);
      chk("post_rst_queue", 32'(exp_q0.size()), 0);

      chk("nib_stable", 32'(viol), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
